mem_access: RTL and testbench

//  Memory-access pipeline stage directly downstream of execute. Takes the ALU

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if -- data-memory bus between the memory-access stage and memory.
//
// Signals:
//   mem_req    request, held high until mem_ack or abort
//   mem_we     1 = store, 0 = load
//   mem_addr   word-aligned byte address
//   mem_be     byte enables, mem_be[3] covers bits [31:24] (byte offset 0)
//   mem_wdata  lane-replicated store data
//   mem_ack    memory completes the outstanding request this cycle
//   mem_rdata  read data, valid together with mem_ack
//
// Modports: master = pipeline stage (drives request), slave = memory.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// mem_access -- memory-access pipeline stage downstream of execute.
//
// Loads and stores run one req/ack transaction on the data-memory bus; all
// other operations pass alu_result straight to writeback. Each accepted
// operation yields exactly one single-cycle wb_valid pulse.
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-low reset
//   in_valid/in_ready upstream handshake (see below)
//   operation         {funct bits[11:10], funct3[9:7], opcode[6:0]}
//   alu_result        effective address or ALU value
//   store_data        rs2 value for stores
//   rd                destination register
//   bus               data-memory bus (master side)
//   wb_valid/we/rd/data  writeback pulse and payload
//   misaligned        pulses with wb_valid on a misaligned access
//   bus_err           pulses with wb_valid on a bus timeout
//   dbg_state         current FSM state (0 = IDLE, 1 = BUS)
//
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is combinational and high exactly in IDLE, so
// upstream stalls while a bus transaction is outstanding. Writeback has no
// ready; the consumer must take wb_valid whenever it pulses. On the bus, the
// request is held with stable addr/we/be/wdata until the edge that samples
// mem_ack=1, or until the wait limit aborts it.
module mem_access #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    mem_access_if.master    bus,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned,
    output logic            bus_err,
    output logic [0:0]      dbg_state
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    logic [0:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    lat_f3;
    logic          lat_store;
    logic [4:0]    lat_rd;
    logic [1:0]    lat_off;

    // ---------------- request decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load, is_store, mem_opc, mem_op, mis;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign opcode = operation[6:0];
    assign funct3 = operation[9:7];
    assign off    = alu_result[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == OPC_LOAD) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
                default:                                is_load = 1'b0;
            endcase
        end
        if (opcode == OPC_STORE) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: is_store = 1'b1;
                default:                is_store = 1'b0;
            endcase
        end
    end

    // Memory opcode regardless of funct3: invalid funct3 still writes nothing.
    assign mem_opc = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign mem_op  = is_load || is_store;

    // funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        mis        = 1'b0;
        be_next    = 4'b1111;
        wdata_next = store_data[31:0];
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b1000 >> off;
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                mis        = off[0];
                be_next    = off[1] ? 4'b0011 : 4'b1100;
                wdata_next = {2{store_data[15:0]}};
            end
            default: begin
                mis        = (off != 2'b00);
                be_next    = 4'b1111;
                wdata_next = store_data[31:0];
            end
        endcase
    end

    // ---------------- load data extraction ----------------
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [XLEN-1:0] load_val;

    always_comb begin
        case (lat_off)
            2'd0:    rbyte = bus.mem_rdata[31:24];
            2'd1:    rbyte = bus.mem_rdata[23:16];
            2'd2:    rbyte = bus.mem_rdata[15:8];
            default: rbyte = bus.mem_rdata[7:0];
        endcase
        rhalf = lat_off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        case (lat_f3)
            3'b000:  load_val = {{(XLEN-8){rbyte[7]}}, rbyte};
            3'b001:  load_val = {{(XLEN-16){rhalf[15]}}, rhalf};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, rbyte};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, rhalf};
            default: load_val = XLEN'(bus.mem_rdata);
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lat_f3        <= '0;
            lat_store     <= 1'b0;
            lat_rd        <= '0;
            lat_off       <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            misaligned    <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            // Pulses default low; payload fields hold their last value.
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mem_op && !mis) begin
                            state         <= BUS;
                            wait_cnt      <= '0;
                            lat_f3        <= funct3;
                            lat_store     <= is_store;
                            lat_rd        <= rd;
                            lat_off       <= off;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_store;
                            bus.mem_addr  <= {alu_result[31:2], 2'b00};
                            bus.mem_be    <= be_next;
                            bus.mem_wdata <= wdata_next;
                        end else begin
                            wb_valid   <= 1'b1;
                            wb_rd      <= rd;
                            wb_data    <= alu_result;
                            wb_we      <= !mem_opc && (rd != 5'd0);
                            misaligned <= mem_op && mis;
                        end
                    end
                end
                BUS: begin
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_rd       <= lat_rd;
                        wb_data     <= lat_store ? '0 : load_val;
                        wb_we       <= !lat_store && (lat_rd != 5'd0);
                    end else if (wait_cnt == LAST_WAIT) begin
                        // MAX_WAIT-th cycle without ack: abandon the request.
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_rd       <= lat_rd;
                        wb_data     <= '0;
                        bus_err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed, table-driven bench for mem_access.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] operation;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        wb_valid, wb_we, misaligned, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [0:0]  dbg_state;

    mem_access_if bus_if ();

    mem_access #(.XLEN(32), .MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd         (rd),
        .bus        (bus_if.master),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    localparam logic [6:0] OPC_ALU   = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum int {K_ALU, K_NOP, K_MIS, K_LOAD, K_STORE} kind_t;

    typedef struct {
        kind_t       kind;
        logic [11:0] op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb_we;
        logic [31:0] exp_wb_data;
    } vec_t;

    function automatic vec_t mk(kind_t k, logic [2:0] f3, logic [6:0] opc,
                                logic [31:0] alu, logic [31:0] sd, logic [4:0] r,
                                int waits, logic [31:0] rdata, logic [31:0] ea,
                                logic [3:0] ebe, logic [31:0] ewd, logic ewe,
                                logic [31:0] ewbd);
        vec_t v;
        v.kind = k; v.op = {2'b00, f3, opc}; v.alu = alu; v.sd = sd; v.rd = r;
        v.waits = waits; v.rdata = rdata; v.exp_addr = ea; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_wb_we = ewe; v.exp_wb_data = ewbd;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_op(input logic [11:0] op, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [4:0] r);
        in_valid   = 1'b1;
        operation  = op;
        alu_result = alu;
        store_data = sd;
        rd         = r;
    endtask

    // One vector: drive at negedge, accept on the next posedge, then follow
    // the bus transaction (if any) cycle by cycle, sampling at negedges.
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({t, ".in_ready"}, 32'(in_ready), 32'd1);
        drive_op(v.op, v.alu, v.sd, v.rd);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (v.kind == K_LOAD || v.kind == K_STORE) begin
            chk({t, ".mem_req"},  32'(bus_if.mem_req), 32'd1);
            chk({t, ".mem_we"},   32'(bus_if.mem_we), 32'(v.kind == K_STORE));
            chk({t, ".mem_addr"}, bus_if.mem_addr, v.exp_addr);
            chk({t, ".mem_be"},   32'(bus_if.mem_be), 32'(v.exp_be));
            if (v.kind == K_STORE) chk({t, ".mem_wdata"}, bus_if.mem_wdata, v.exp_wdata);
            chk({t, ".busy"},     32'(in_ready), 32'd0);
            for (int w = 0; w < v.waits; w++) begin
                @(posedge clk);
                @(negedge clk);
                chk({t, ".wait_req"},   32'(bus_if.mem_req), 32'd1);
                chk({t, ".wait_busy"},  32'(in_ready), 32'd0);
                chk({t, ".wait_addr"},  bus_if.mem_addr, v.exp_addr);
            end
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = 32'h5555_AAAA;
            chk({t, ".req_drop"}, 32'(bus_if.mem_req), 32'd0);
            if (v.kind == K_LOAD) chk({t, ".wb_data"}, wb_data, v.exp_wb_data);
        end else begin
            chk({t, ".no_req"}, 32'(bus_if.mem_req), 32'd0);
            if (v.kind == K_ALU) chk({t, ".wb_data"}, wb_data, v.exp_wb_data);
        end
        chk({t, ".wb_valid"},   32'(wb_valid), 32'd1);
        chk({t, ".wb_we"},      32'(wb_we), 32'(v.exp_wb_we));
        chk({t, ".wb_rd"},      32'(wb_rd), 32'(v.rd));
        chk({t, ".misaligned"}, 32'(misaligned), 32'(v.kind == K_MIS));
        chk({t, ".bus_err"},    32'(bus_err), 32'd0);
        chk({t, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[16];

    // ---------------- stimulus ----------------
    initial begin
        //            kind     f3      opcode     alu           sd            rd  w  rdata         addr          be       wdata         we   wb_data
        vecs[0]  = mk(K_ALU,   3'b000, OPC_ALU,   32'h0000_0005, 32'h0,        3, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_0005);
        vecs[1]  = mk(K_ALU,   3'b111, OPC_ALU,   32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'hDEAD_BEEF);
        vecs[2]  = mk(K_LOAD,  3'b000, OPC_LOAD,  32'h0000_0103, 32'h0,        5, 0, 32'h1122_3380, 32'h0000_0100, 4'b0001, 32'h0,        1'b1, 32'hFFFF_FF80);
        vecs[3]  = mk(K_LOAD,  3'b100, OPC_LOAD,  32'h0000_0103, 32'h0,        5, 0, 32'h1122_3380, 32'h0000_0100, 4'b0001, 32'h0,        1'b1, 32'h0000_0080);
        vecs[4]  = mk(K_LOAD,  3'b001, OPC_LOAD,  32'h0000_0102, 32'h0,        7, 1, 32'h1122_8001, 32'h0000_0100, 4'b0011, 32'h0,        1'b1, 32'hFFFF_8001);
        vecs[5]  = mk(K_LOAD,  3'b101, OPC_LOAD,  32'h0000_0100, 32'h0,        8, 2, 32'h9876_5432, 32'h0000_0100, 4'b1100, 32'h0,        1'b1, 32'h0000_9876);
        vecs[6]  = mk(K_LOAD,  3'b010, OPC_LOAD,  32'h0000_0204, 32'h0,        0, 0, 32'hCAFE_F00D, 32'h0000_0204, 4'b1111, 32'h0,        1'b0, 32'hCAFE_F00D);
        vecs[7]  = mk(K_STORE, 3'b001, OPC_STORE, 32'h0000_0202, 32'h0000_ABCD, 9, 3, 32'h0,        32'h0000_0200, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h0);
        vecs[8]  = mk(K_STORE, 3'b000, OPC_STORE, 32'h0000_0101, 32'h1234_56A5, 4, 1, 32'h0,        32'h0000_0100, 4'b0100, 32'hA5A5_A5A5, 1'b0, 32'h0);
        vecs[9]  = mk(K_STORE, 3'b010, OPC_STORE, 32'h0000_0030, 32'h0102_0304, 6, 0, 32'h0,        32'h0000_0030, 4'b1111, 32'h0102_0304, 1'b0, 32'h0);
        vecs[10] = mk(K_MIS,   3'b010, OPC_LOAD,  32'h0000_0101, 32'h0,        2, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[11] = mk(K_MIS,   3'b001, OPC_STORE, 32'h0000_0203, 32'h0,        2, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[12] = mk(K_MIS,   3'b101, OPC_LOAD,  32'h0000_0001, 32'h0,        2, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[13] = mk(K_NOP,   3'b011, OPC_LOAD,  32'h0000_0040, 32'h0,       11, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[14] = mk(K_LOAD,  3'b000, OPC_LOAD,  32'h0000_0100, 32'h0,       12, 0, 32'h7F00_0000, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'h0000_007F);
        vecs[15] = mk(K_LOAD,  3'b100, OPC_LOAD,  32'h0000_0102, 32'h0,       13, 1, 32'h00A5_5A00, 32'h0000_0100, 4'b0010, 32'h0,        1'b1, 32'h0000_005A);

        // ---- reset ----
        reset            = 1'b0;
        in_valid         = 1'b0;
        operation        = '0;
        alu_result       = '0;
        store_data       = '0;
        rd               = '0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.mem_req",   32'(bus_if.mem_req), 32'd0);
        chk("rst.mem_addr",  bus_if.mem_addr, 32'd0);
        chk("rst.mem_be",    32'(bus_if.mem_be), 32'd0);
        chk("rst.wb_valid",  32'(wb_valid), 32'd0);
        chk("rst.wb_data",   wb_data, 32'd0);
        chk("rst.state",     32'(dbg_state), 32'd0);
        reset = 1'b1;

        // ---- mem_ack while idle is ignored ----
        @(negedge clk);
        bus_if.mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        chk("idle_ack.wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_ack.mem_req",  32'(bus_if.mem_req), 32'd0);

        // ---- vector table ----
        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // ---- three back-to-back ALU ops ----
        @(negedge clk);
        drive_op({5'b00000, OPC_ALU}, 32'h0000_0011, 32'h0, 5'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.ready1", 32'(in_ready), 32'd1);
        drive_op({5'b00000, OPC_ALU}, 32'h0000_0022, 32'h0, 5'd2);
        chk("b2b.wb1", wb_data, 32'h0000_0011);
        chk("b2b.v1",  32'(wb_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive_op({5'b00000, OPC_ALU}, 32'h0000_0033, 32'h0, 5'd3);
        chk("b2b.wb2", wb_data, 32'h0000_0022);
        chk("b2b.v2",  32'(wb_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.wb3", wb_data, 32'h0000_0033);
        chk("b2b.v3",  32'(wb_valid), 32'd1);
        chk("b2b.rd3", 32'(wb_rd), 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.v_end", 32'(wb_valid), 32'd0);

        // ---- LW with no ack: abort after 15 BUS cycles, late ack ignored ----
        drive_op({2'b00, 3'b010, OPC_LOAD}, 32'h0000_0400, 32'h0, 5'd10);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("to.req_c1", 32'(bus_if.mem_req), 32'd1);
        for (int c = 2; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("to.req_c%0d", c), 32'(bus_if.mem_req), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("to.req_drop", 32'(bus_if.mem_req), 32'd0);
        chk("to.bus_err",  32'(bus_err), 32'd1);
        chk("to.wb_valid", 32'(wb_valid), 32'd1);
        chk("to.wb_we",    32'(wb_we), 32'd0);
        chk("to.mis",      32'(misaligned), 32'd0);
        chk("to.ready",    32'(in_ready), 32'd1);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        chk("late_ack.wb_valid", 32'(wb_valid), 32'd0);
        chk("late_ack.bus_err",  32'(bus_err), 32'd0);
        chk("late_ack.mem_req",  32'(bus_if.mem_req), 32'd0);

        // ---- reset during BUS ----
        drive_op({2'b00, 3'b010, OPC_STORE}, 32'h0000_0500, 32'hFEED_0001, 5'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rbus.req_before", 32'(bus_if.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rbus.req_async",  32'(bus_if.mem_req), 32'd0);
        chk("rbus.ready",      32'(in_ready), 32'd1);
        chk("rbus.mem_we",     32'(bus_if.mem_we), 32'd0);
        chk("rbus.mem_addr",   bus_if.mem_addr, 32'd0);
        chk("rbus.mem_wdata",  bus_if.mem_wdata, 32'd0);
        chk("rbus.wb_valid",   32'(wb_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(100, vecs[2]);
        run_vec(101, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
